rs_decoder: RTL and testbench

RS_DECODER -- requirements
Module: rs_decoder

---
 rtl/rs_pkg.sv | 38 +++
 rtl/gf256_mul.sv | 25 ++
 rtl/rs_decoder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_rs_decoder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions for the RS(255,251) decoder.
// Holds the code dimensions, the GF(2^8) field polynomial 0x11D, the
// alpha powers used by the Horner syndrome update (alpha^0..alpha^3), the
// position-step constant alpha^-1, the input framing state type and a
// GF(2^8) multiply function intended for constant operands.
package rs_pkg;

    localparam int RS_NN = 255;
    localparam int RS_KK = 251;
    localparam int RS_TT = 2;

    localparam logic [8:0] GF_POLY    = 9'h11D;
    localparam logic [7:0] GF_POLY_LO = GF_POLY[7:0];

    // alpha^i for syndrome i; alpha = 0x02 in this field.
    localparam logic [7:0] ALPHA_POW [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    // alpha^-1 == alpha^254, also the locator value of position k=254.
    localparam logic [7:0] ALPHA_INV = 8'h8E;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_FRAME,
        IN_DROP
    } in_state_e;

    function automatic logic [7:0] gf_cmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY_LO : 8'h00);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational general GF(2^8) multiplier over the 0x11D field.
// Ports: a, b - operands; p - product a*b.
module gf256_mul
    import rs_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: sh walks through a*x^i reduced modulo the field polynomial.
    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY_LO : 8'h00);
        end
        p = acc;
    end

endmodule

// File: rtl/rs_decoder.sv
// Single-error-correcting RS(255,251) decoder.
// Input side: frames symbols into a ping-pong buffer while computing four
// syndromes by Horner. On a well-formed frame end the syndromes are latched,
// the banks swap and the stored word is replayed with a per-position
// single-error locator test; matching symbols are corrected by XOR with S0.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   din_val/din_sop/din_eop   - input symbol strobe and frame markers
//   din                       - received symbol, power 254 first
//   dout_val/dout_sop/dout_eop/dout - corrected data symbols (first KK only)
//   dec_done/dec_corr/dec_fail/err_pos - per-codeword status
//   frm_err                   - malformed frame discarded
//   busy                      - next write bank still being read
module rs_decoder
    import rs_pkg::*;
#(
    parameter int NN = RS_NN,
    parameter int KK = RS_KK,
    parameter int TT = RS_TT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_val,
    input  logic       din_sop,
    input  logic       din_eop,
    input  logic [7:0] din,
    output logic       dout_val,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic [7:0] dout,
    output logic       dec_done,
    output logic       dec_corr,
    output logic       dec_fail,
    output logic [7:0] err_pos,
    output logic       frm_err,
    output logic       busy
);

    localparam int         NPAR      = 2 * TT;
    localparam logic [7:0] LAST_ADDR = 8'(NN - 1);
    localparam logic [7:0] KK_W      = 8'(KK);
    localparam logic [7:0] KK_LAST   = 8'(KK - 1);

    // Input framing state
    in_state_e  state_q, state_d;
    logic [7:0] wr_cnt_q, wr_cnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic [7:0] syn_q [NPAR];
    logic [7:0] syn_d [NPAR];
    logic [7:0] syn_acc [NPAR];
    logic [7:0] syn_lat_q [NPAR];
    logic [7:0] syn_lat_d [NPAR];
    logic       frm_err_q, frm_err_d;
    logic       we;
    logic [7:0] wr_addr;
    logic       start_rd;

    // Readout stage p1 (address issue)
    logic       rd_act_q, rd_act_d;
    logic [7:0] rd_cnt_q, rd_cnt_d;
    logic       rd_bank_q, rd_bank_d;

    // Readout stage p2 (locator test)
    logic       vld_p2_q, first_p2_q, last_p2_q;
    logic [7:0] idx_p2_q;
    logic [7:0] rdata_p2_q;
    logic [7:0] syn_p2_q [NPAR];
    logic [7:0] syn_p2_d [NPAR];
    logic [7:0] a_q, a_d;
    logic [7:0] prod0, prod1, prod2;
    logic       match;

    // Stage p3 (outputs and per-codeword tally)
    logic       dout_val_q, dout_val_d;
    logic       dout_sop_q, dout_sop_d;
    logic       dout_eop_q, dout_eop_d;
    logic [7:0] dout_q, dout_d;
    logic [1:0] mcnt_q, mcnt_d;
    logic       zero_q, zero_d;
    logic [7:0] pos_q, pos_d;
    logic       done_p3_q, done_p3_d;

    // Status registers
    logic       dec_done_q, dec_done_d;
    logic       dec_corr_q, dec_corr_d;
    logic       dec_fail_q, dec_fail_d;
    logic [7:0] err_pos_q, err_pos_d;

    logic [7:0] mem [0:511];
    logic       busy_w;

    // The bank the next frame will fill is busy only while it is being replayed.
    assign busy_w = rd_act_q && (rd_bank_q == wr_bank_q);

    gf256_mul u_mul0 (.a(syn_p2_q[0]), .b(a_q), .p(prod0));
    gf256_mul u_mul1 (.a(syn_p2_q[1]), .b(a_q), .p(prod1));
    gf256_mul u_mul2 (.a(syn_p2_q[2]), .b(a_q), .p(prod2));

    // ---- input stage: framing, syndromes, buffer write ----
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        frm_err_d = 1'b0;
        we        = 1'b0;
        wr_addr   = wr_cnt_q;
        start_rd  = 1'b0;
        rd_act_d  = rd_act_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        for (int i = 0; i < NPAR; i++) begin
            syn_acc[i]   = gf_cmul(syn_q[i], ALPHA_POW[i]) ^ din;
            syn_d[i]     = syn_q[i];
            syn_lat_d[i] = syn_lat_q[i];
        end

        if (din_val) begin
            if (din_sop) begin
                if (busy_w) begin
                    state_d   = IN_DROP;
                    frm_err_d = 1'b1;
                end else begin
                    // A sop inside a frame abandons the partial frame.
                    frm_err_d = (state_q == IN_FRAME) || din_eop;
                    state_d   = din_eop ? IN_IDLE : IN_FRAME;
                    we        = 1'b1;
                    wr_addr   = 8'd0;
                    wr_cnt_d  = 8'd1;
                    for (int i = 0; i < NPAR; i++) syn_d[i] = din;
                end
            end else if (state_q == IN_FRAME) begin
                we       = 1'b1;
                wr_cnt_d = wr_cnt_q + 8'd1;
                for (int i = 0; i < NPAR; i++) syn_d[i] = syn_acc[i];
                if (wr_cnt_q == LAST_ADDR) begin
                    state_d   = IN_IDLE;
                    start_rd  = din_eop;
                    frm_err_d = !din_eop;
                end else if (din_eop) begin
                    state_d   = IN_IDLE;
                    frm_err_d = 1'b1;
                end
            end else if (state_q == IN_DROP && din_eop) begin
                state_d = IN_IDLE;
            end
        end

        if (start_rd) begin
            for (int i = 0; i < NPAR; i++) syn_lat_d[i] = syn_acc[i];
            rd_act_d  = 1'b1;
            rd_cnt_d  = 8'd0;
            rd_bank_d = wr_bank_q;
            wr_bank_d = !wr_bank_q;
        end else if (rd_act_q) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
            if (rd_cnt_q == LAST_ADDR) rd_act_d = 1'b0;
        end
    end

    // ---- p1 -> p2: per-codeword locator setup ----
    always_comb begin
        for (int i = 0; i < NPAR; i++) syn_p2_d[i] = syn_p2_q[i];
        a_d = a_q;
        if (rd_act_q && rd_cnt_q == 8'd0) begin
            // Syndromes move to a second copy so a following frame can latch its own.
            for (int i = 0; i < NPAR; i++) syn_p2_d[i] = syn_lat_q[i];
            a_d = ALPHA_INV;
        end else if (vld_p2_q) begin
            a_d = gf_cmul(a_q, ALPHA_INV);
        end
    end

    // ---- p2 -> p3: locator test, correction, tally ----
    always_comb begin
        match = vld_p2_q && (syn_p2_q[0] != 8'h00) && (syn_p2_q[1] == prod0) &&
                (syn_p2_q[2] == prod1) && (syn_p2_q[3] == prod2);

        dout_val_d = vld_p2_q && (idx_p2_q < KK_W);
        dout_sop_d = vld_p2_q && first_p2_q;
        dout_eop_d = vld_p2_q && (idx_p2_q == KK_LAST);
        dout_d     = dout_val_d ? (rdata_p2_q ^ (match ? syn_p2_q[0] : 8'h00)) : 8'h00;
        done_p3_d  = vld_p2_q && last_p2_q;

        mcnt_d = mcnt_q;
        zero_d = zero_q;
        pos_d  = pos_q;
        if (vld_p2_q) begin
            if (first_p2_q) begin
                mcnt_d = match ? 2'd1 : 2'd0;
                zero_d = (syn_p2_q[0] == 8'h00) && (syn_p2_q[1] == 8'h00) &&
                         (syn_p2_q[2] == 8'h00) && (syn_p2_q[3] == 8'h00);
            end else if (match) begin
                mcnt_d = (mcnt_q == 2'd0) ? 2'd1 : 2'd2;
            end
            if (match) pos_d = LAST_ADDR - idx_p2_q;
        end

        // Status sees the finished tally one cycle after the last position.
        dec_done_d = done_p3_q;
        dec_corr_d = dec_corr_q;
        dec_fail_d = dec_fail_q;
        err_pos_d  = err_pos_q;
        if (done_p3_q) begin
            dec_corr_d = !zero_q && (mcnt_q == 2'd1);
            dec_fail_d = !zero_q && (mcnt_q != 2'd1);
            err_pos_d  = (!zero_q && (mcnt_q == 2'd1)) ? pos_q : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank_q, wr_addr}] <= din;
        rdata_p2_q <= mem[{rd_bank_q, rd_cnt_q}];
        idx_p2_q   <= rd_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IN_IDLE;
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            rd_act_q   <= 1'b0;
            rd_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            vld_p2_q   <= 1'b0;
            first_p2_q <= 1'b0;
            last_p2_q  <= 1'b0;
            a_q        <= '0;
            dout_val_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
            dout_q     <= '0;
            mcnt_q     <= '0;
            zero_q     <= 1'b0;
            pos_q      <= '0;
            done_p3_q  <= 1'b0;
            dec_done_q <= 1'b0;
            dec_corr_q <= 1'b0;
            dec_fail_q <= 1'b0;
            err_pos_q  <= '0;
            for (int i = 0; i < NPAR; i++) begin
                syn_q[i]     <= '0;
                syn_lat_q[i] <= '0;
                syn_p2_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            frm_err_q  <= frm_err_d;
            rd_act_q   <= rd_act_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_bank_q  <= rd_bank_d;
            vld_p2_q   <= rd_act_q;
            first_p2_q <= rd_act_q && (rd_cnt_q == 8'd0);
            last_p2_q  <= rd_act_q && (rd_cnt_q == LAST_ADDR);
            a_q        <= a_d;
            dout_val_q <= dout_val_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
            dout_q     <= dout_d;
            mcnt_q     <= mcnt_d;
            zero_q     <= zero_d;
            pos_q      <= pos_d;
            done_p3_q  <= done_p3_d;
            dec_done_q <= dec_done_d;
            dec_corr_q <= dec_corr_d;
            dec_fail_q <= dec_fail_d;
            err_pos_q  <= err_pos_d;
            for (int i = 0; i < NPAR; i++) begin
                syn_q[i]     <= syn_d[i];
                syn_lat_q[i] <= syn_lat_d[i];
                syn_p2_q[i]  <= syn_p2_d[i];
            end
        end
    end

    assign dout_val = dout_val_q;
    assign dout_sop = dout_sop_q;
    assign dout_eop = dout_eop_q;
    assign dout     = dout_q;
    assign dec_done = dec_done_q;
    assign dec_corr = dec_corr_q;
    assign dec_fail = dec_fail_q;
    assign err_pos  = err_pos_q;
    assign frm_err  = frm_err_q;
    assign busy     = busy_w;

endmodule

// File: tb/tb_rs_decoder.sv
// Scoreboard bench for rs_decoder: the driver pushes expected symbols and
// status (from a table-based GF model evaluating syndromes directly) and a
// monitor pops and compares whenever the decoder presents output.
module tb_rs_decoder;

    localparam int NN = 255;
    localparam int KK = 251;

    logic       clk = 1'b0;
    logic       rst, din_val, din_sop, din_eop;
    logic [7:0] din;
    logic       dout_val, dout_sop, dout_eop, dec_done, dec_corr, dec_fail, frm_err, busy;
    logic [7:0] dout, err_pos;

    always #5 clk = ~clk;

    rs_decoder #(.NN(255), .KK(251), .TT(2)) dut (
        .clk(clk), .rst(rst), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop),
        .din(din), .dout_val(dout_val), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout(dout), .dec_done(dec_done), .dec_corr(dec_corr), .dec_fail(dec_fail),
        .err_pos(err_pos), .frm_err(frm_err), .busy(busy)
    );

    typedef struct { logic [7:0] d; logic sop; logic eop; } dexp_t;
    typedef struct { int cyc; logic corr; logic fail; logic [7:0] pos; } sexp_t;

    dexp_t      exp_q[$];
    int         sop_q[$];
    sexp_t      st_q[$];
    int         sop_hist[$];
    int         exp_t[256];
    int         log_t[256];
    int         gpoly[5];
    logic [7:0] tx[NN];
    int         total = 0, bad = 0, cyc = 0;
    int         frm_seen = 0, frm_exp = 0, done_seen = 0, done_exp = 0;
    bit         busy_seen = 1'b0;
    logic       last_corr = 1'bx, last_fail = 1'bx;
    logic [7:0] last_pos = 8'hxx, last_first = 8'hxx;

    always @(posedge clk) cyc <= cyc + 1;

    function void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function void build_tables();
        int x, ng[5];
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if (x & 256) x = x ^ 'h11D;
        end
        gpoly = '{1, 0, 0, 0, 0};
        for (int r = 0; r < 4; r++) begin
            ng[0] = gmul(gpoly[0], exp_t[r]);
            for (int j = 1; j < 5; j++) ng[j] = gpoly[j-1] ^ gmul(gpoly[j], exp_t[r]);
            gpoly = ng;
        end
    endfunction

    // Systematic encoding of tx[0..KK-1] by division by the generator polynomial.
    function void encode();
        int rem[4], fb;
        rem = '{0, 0, 0, 0};
        for (int j = 0; j < KK; j++) begin
            fb = tx[j] ^ rem[3];
            rem[3] = rem[2] ^ gmul(fb, gpoly[3]);
            rem[2] = rem[1] ^ gmul(fb, gpoly[2]);
            rem[1] = rem[0] ^ gmul(fb, gpoly[1]);
            rem[0] = gmul(fb, gpoly[0]);
        end
        for (int i = 0; i < 4; i++) tx[KK + i] = 8'(rem[3 - i]);
    endfunction

    function void load_ramp();
        for (int j = 0; j < KK; j++) tx[j] = 8'(251 - j);
        encode();
    endfunction

    // Reference: syndromes by direct polynomial evaluation, then the locator rule per position.
    function void push_expect(input int t);
        int    s[4], nmatch, mpos, a;
        bit    hit[NN];
        dexp_t de;
        sexp_t se;
        for (int i = 0; i < 4; i++) begin
            s[i] = 0;
            for (int j = 0; j < NN; j++) s[i] ^= gmul(tx[j], exp_t[(i * (254 - j)) % 255]);
        end
        nmatch = 0;
        mpos   = 0;
        for (int k = 0; k < NN; k++) begin
            a = exp_t[k];
            hit[k] = (s[0] != 0) && (s[1] == gmul(s[0], a)) && (s[2] == gmul(s[1], a)) &&
                     (s[3] == gmul(s[2], a));
            if (hit[k]) begin nmatch++; mpos = k; end
        end
        for (int j = 0; j < KK; j++) begin
            de.d   = tx[j] ^ (hit[254 - j] ? 8'(s[0]) : 8'h00);
            de.sop = (j == 0);
            de.eop = (j == KK - 1);
            exp_q.push_back(de);
        end
        sop_q.push_back(t + 3);
        se.cyc  = t + 258;
        se.corr = 1'b0;
        se.fail = 1'b0;
        se.pos  = 8'h00;
        if (s[0] != 0 || s[1] != 0 || s[2] != 0 || s[3] != 0) begin
            if (nmatch == 1) begin se.corr = 1'b1; se.pos = 8'(mpos); end
            else se.fail = 1'b1;
        end
        st_q.push_back(se);
        done_exp++;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'($urandom);
        end
    endtask

    task automatic drive_frame(input int nsym, input bit with_eop, input int gap_pct);
        for (int j = 0; j < nsym; j++) begin
            if (j > 0)
                for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
                    @(negedge clk);
                    din_val = 1'b0; din_sop = 1'b1; din_eop = 1'b1; din = 8'($urandom);
                end
            @(negedge clk);
            din_val = 1'b1;
            din_sop = (j == 0);
            din_eop = with_eop && (j == nsym - 1);
            din     = tx[j];
            if (din_eop && nsym == NN) push_expect(cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        done_exp -= st_q.size();
        exp_q.delete(); sop_q.delete(); st_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor
    initial begin
        dexp_t de;
        sexp_t se;
        forever begin
            @(posedge clk);
            #1;
            if (dout_val) begin
                if (exp_q.size() == 0) chk("dout_unexpected", 1, 0);
                else begin
                    de = exp_q.pop_front();
                    chk("dout", dout, de.d);
                    chk("dout_sop", dout_sop, de.sop);
                    chk("dout_eop", dout_eop, de.eop);
                end
            end else if (dout_sop || dout_eop) chk("marker_without_val", 1, 0);
            if (dout_sop) begin
                last_first = dout;
                sop_hist.push_back(cyc);
                if (sop_q.size() == 0) chk("sop_unexpected", 1, 0);
                else chk("sop_cycle", cyc, sop_q.pop_front());
            end
            if (dec_done) begin
                done_seen++;
                last_corr = dec_corr; last_fail = dec_fail; last_pos = err_pos;
                if (st_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    se = st_q.pop_front();
                    chk("done_cycle", cyc, se.cyc);
                    chk("dec_corr", dec_corr, se.corr);
                    chk("dec_fail", dec_fail, se.fail);
                    if (se.corr) chk("err_pos", err_pos, se.pos);
                end
            end
            if (frm_err) frm_seen++;
            if (busy) busy_seen = 1'b1;
        end
    end

    initial begin
        int nerr, p, gap;
        build_tables();
        rst = 1'b1; din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_dout_val", dout_val, 0);
        chk("rst_dout_sop", dout_sop, 0);
        chk("rst_dout_eop", dout_eop, 0);
        chk("rst_dout", dout, 0);
        chk("rst_dec_done", dec_done, 0);
        chk("rst_dec_corr", dec_corr, 0);
        chk("rst_dec_fail", dec_fail, 0);
        chk("rst_err_pos", err_pos, 0);
        chk("rst_frm_err", frm_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(4);

        // Clean codeword
        load_ramp();
        drive_frame(NN, 1, 0); idle(270);
        chk("clean_corr", last_corr, 0);
        chk("clean_fail", last_fail, 0);
        chk("clean_first", last_first, 251);

        // First symbol corrupted
        load_ramp(); tx[0] ^= 8'h5A;
        drive_frame(NN, 1, 20); idle(270);
        chk("k254_corr", last_corr, 1);
        chk("k254_pos", last_pos, 254);
        chk("k254_first", last_first, 251);

        // Last parity symbol corrupted
        load_ramp(); tx[254] ^= 8'hFF;
        drive_frame(NN, 1, 0); idle(270);
        chk("k0_corr", last_corr, 1);
        chk("k0_pos", last_pos, 0);

        // Two errors: k=200 and k=100
        load_ramp(); tx[54] ^= 8'h11; tx[154] ^= 8'h22;
        drive_frame(NN, 1, 0); idle(270);
        chk("two_err_fail", last_fail, 1);
        chk("two_err_corr", last_corr, 0);

        // Back-to-back frames
        load_ramp();
        drive_frame(NN, 1, 0); drive_frame(NN, 1, 0); idle(530);
        chk("b2b_sop_spacing", sop_hist[sop_hist.size()-1] - sop_hist[sop_hist.size()-2], 255);
        chk("b2b_busy", busy_seen, 0);

        // Short frame, then reset mid-frame
        load_ramp();
        drive_frame(100, 1, 0); frm_exp++; idle(5);
        chk("short_frm_err", frm_seen, frm_exp);
        drive_frame(50, 0, 0);
        do_reset(); idle(300);

        // Reset in the middle of readout
        drive_frame(NN, 1, 0); idle(100);
        do_reset(); idle(300);

        // Restart by a sop mid-frame, then overlong frame without eop
        drive_frame(30, 0, 10); frm_exp++;
        load_ramp(); tx[77] ^= 8'h3C;
        drive_frame(NN, 1, 0); idle(270);
        chk("restart_corr", last_corr, 1);
        chk("restart_pos", last_pos, 254 - 77);
        drive_frame(NN, 0, 0); frm_exp++; idle(5);
        chk("overlong_frm_err", frm_seen, frm_exp);

        // Randomized codewords with 0..3 symbol errors, gaps and back-to-back runs
        for (int f = 0; f < 12; f++) begin
            for (int j = 0; j < KK; j++) tx[j] = 8'($urandom);
            encode();
            nerr = $urandom_range(3);
            for (int e = 0; e < nerr; e++) begin
                p = $urandom_range(NN - 1);
                tx[p] ^= 8'($urandom_range(255, 1));
            end
            gap = ($urandom_range(1) == 1) ? 0 : int'($urandom_range(30));
            drive_frame(NN, 1, gap);
            if ($urandom_range(1) == 1) idle($urandom_range(20));
        end
        idle(2);

        for (int i = 0; i < 3000 && (exp_q.size() != 0 || st_q.size() != 0 || sop_q.size() != 0); i++)
            @(negedge clk);
        chk("drain_data", exp_q.size(), 0);
        chk("drain_status", st_q.size(), 0);
        chk("drain_sop", sop_q.size(), 0);
        chk("frm_err_count", frm_seen, frm_exp);
        chk("done_count", done_seen, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
